// File: rtl/chk_pkg.sv
// Shared types for the result checker: FSM states, the "no mismatch yet" marker
// and the verdict encoding used when reporting a run.
package chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TOUT
  } state_t;

  typedef enum logic [1:0] {
    VERDICT_NONE,
    VERDICT_PASS,
    VERDICT_FAIL,
    VERDICT_TOUT
  } verdict_t;

  localparam int DEFAULT_CNT_W = 16;
  localparam logic [DEFAULT_CNT_W-1:0] NO_MISMATCH = '1;

  // Status bits in port order: {busy, done, pass, fail, timeout}
  function automatic logic [4:0] status_of(state_t s);
    return {s == ST_RUN,
            s == ST_PASS || s == ST_FAIL || s == ST_TOUT,
            s == ST_PASS,
            s == ST_FAIL,
            s == ST_TOUT};
  endfunction

  function automatic verdict_t verdict_of(logic pass, logic fail, logic timeout);
    if (pass)    return VERDICT_PASS;
    if (fail)    return VERDICT_FAIL;
    if (timeout) return VERDICT_TOUT;
    return VERDICT_NONE;
  endfunction

endpackage

// File: rtl/tb_result_checker_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/tb_result_checker.sv
// Observes a DUT/reference output pair, counts samples and mismatches and
// settles on a single PASS, FAIL or TIMEOUT verdict per run.
module tb_result_checker
  import chk_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter int CNT_W        = 16,
  parameter int CHECK_LEN    = 10,
  parameter int TIMEOUT_CYC  = 100,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] your_out,
  input  logic [DATA_W-1:0] ref_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  first_mismatch_cycle,
  output logic [CNT_W-1:0]  cycle_cnt
);

  state_t     state;
  logic [4:0] status;
  logic       run;
  logic       start_ok;
  logic       take;
  logic       miss;
  logic       last_sample;
  logic       timed_out;

  assign run      = (state == ST_RUN);
  assign start_ok = start && !run;
  assign take     = run && sample_en;
  // Case inequality so X/Z on either stream is graded as a mismatch
  assign miss        = take && (your_out !== ref_out);
  assign last_sample = take && (sample_cnt == CNT_W'(CHECK_LEN - 1));
  assign timed_out   = (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  assign {busy, done, pass, fail, timeout} = status;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .inc   (run),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .inc   (take),
    .count (sample_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .inc   (miss),
    .count (mismatch_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      first_mismatch_cycle <= '1;
    end else if (miss && first_mismatch_cycle == '1) begin
      first_mismatch_cycle <= cycle_cnt;
    end
  end

  // Sample-based verdicts are checked before the timeout so a final sample on
  // the last budgeted cycle still earns PASS/FAIL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      status <= status_of(ST_IDLE);
    end else if (start_ok) begin
      state  <= ST_RUN;
      status <= status_of(ST_RUN);
    end else if (run) begin
      if (miss && STOP_ON_FAIL != 0) begin
        state  <= ST_FAIL;
        status <= status_of(ST_FAIL);
      end else if (last_sample) begin
        if (mismatch_cnt != '0 || miss) begin
          state  <= ST_FAIL;
          status <= status_of(ST_FAIL);
        end else begin
          state  <= ST_PASS;
          status <= status_of(ST_PASS);
        end
      end else if (timed_out) begin
        state  <= ST_TOUT;
        status <= status_of(ST_TOUT);
      end
    end
  end

endmodule
